ftdi_byte_fifo: RTL
===================

FTDI_BYTE_FIFO -- requirements
Module: ftdi_byte_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of storage depth (DEPTH = 2^DEPTH_LOG2 bytes, legal range 2..10).
REQ-002 Parameter AFULL_LEVEL, default 12, occupancy at or above which oAlmostFull asserts (legal range 1..DEPTH).
REQ-003 iClk  input  1  single system clock; all logic on rising edge.
REQ-004 iRst_n  input  1  asynchronous active-low reset.
REQ-005 iWrEn  input  1  write request; driven by the FTDI bridge oRxWrEn (Rx instance) or by core logic (Tx instance).
REQ-006 iWrData  input  8  byte written when the write is accepted.
REQ-007 oFull  output  1  no free entry; drives the bridge iRxWrFull.
REQ-008 oAlmostFull  output  1  occupancy >= AFULL_LEVEL.
REQ-009 iRdEn  input  1  read request; driven by the bridge oTxRdEn (Tx instance) or by core logic (Rx instance).
REQ-010 oRdData  output  8  registered read data; drives the bridge iTxData.
REQ-011 oEmpty  output  1  no stored byte; drives the bridge iTxRdEmpty.
REQ-012 oCount  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-013 iErrClr  input  1  clears sticky error flags (present only with FIFO_ERR_FLAGS_EN).
REQ-014 oOverflow, oUnderflow  output  1 each  sticky error flags (present only with FIFO_ERR_FLAGS_EN).

Function
REQ-015 Storage: DEPTH x 8 array; write pointer and read pointer each DEPTH_LOG2 bits, wrapping from DEPTH-1 to 0.
REQ-016 Write accepted when iWrEn=1 and (oFull=0 or an accepted read occurs in the same cycle); byte stored at write pointer, pointer +1.
REQ-017 Read accepted when iRdEn=1 and oEmpty=0; byte at read pointer loaded into oRdData on that rising edge, pointer +1.
REQ-018 Read latency: oRdData valid on the first cycle after the accepted-read edge and held until the next accepted read.
REQ-019 Rejected read (empty): oRdData, pointers, oCount unchanged.
REQ-020 Rejected write (full, no simultaneous read): array, pointers, oCount unchanged.
REQ-021 oCount: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-022 Simultaneous read and write at full: both accepted, oCount stays DEPTH, oFull stays 1.
REQ-023 Simultaneous read and write at empty: write accepted, read rejected (no write-to-read bypass), oCount becomes 1.
REQ-024 oFull, oEmpty, oAlmostFull registered, derived from next-state oCount so they are exact on the cycle following each update.
REQ-025 Pointer wrap-around transparent: byte order preserved across any number of wraps.

Reset
REQ-026 iRst_n=0 asynchronously forces: pointers 0, oCount 0, oEmpty 1, oFull 0, oAlmostFull 0, oRdData 8'h00, oOverflow 0, oUnderflow 0.
REQ-027 Array contents not reset; reset mid-operation discards all stored bytes.
REQ-028 Reset release synchronous to iClk; first write accepted on the first rising edge with iRst_n=1.

Configuration
REQ-029 Macro FTDI_FIFO_ERR_FLAGS_EN defined: oOverflow sets on rejected write, oUnderflow sets on rejected read, both sticky until iErrClr=1 (clear wins over set in same cycle).
REQ-030 Macro undefined: iErrClr, oOverflow, oUnderflow ports and logic absent; all other behaviour identical.

Verification
REQ-031 Reset, write 8'hAA, read one cycle later -> oRdData=8'hAA the cycle after iRdEn, oEmpty returns to 1, oCount 1 then 0.
REQ-032 Write 16 bytes 8'h00..8'h0F (DEPTH_LOG2=4) -> oAlmostFull at count 12, oFull at 16; 17th write 8'hFF rejected; 16 reads return 8'h00..8'h0F in order.
REQ-033 At full, assert iWrEn and iRdEn together with 8'h55 -> oCount stays 16, oldest byte read, 8'h55 emerges last.
REQ-034 At empty, assert iWrEn(8'h3C) and iRdEn together -> oRdData unchanged, oCount=1; next read returns 8'h3C.
REQ-035 Write/read 40 bytes streaming at count 1-3 -> pointers wrap twice, all 40 bytes returned in order.
REQ-036 With FTDI_FIFO_ERR_FLAGS_EN: read while empty -> oUnderflow=1 and holds; pulse iErrClr -> 0; drop iRst_n mid-burst at count 5 -> oCount=0, oEmpty=1 immediately.

Source files
------------

// File: rtl/ftdi_byte_fifo.sv
// Single-clock byte FIFO between the FTDI bridge and core logic, with registered read data.
// Optional sticky overflow/underflow flags are built when FTDI_FIFO_ERR_FLAGS_EN is defined.
module ftdi_byte_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iWrEn,
    input  logic [7:0]            iWrData,
    output logic                  oFull,
    output logic                  oAlmostFull,
    input  logic                  iRdEn,
`ifdef FTDI_FIFO_ERR_FLAGS_EN
    input  logic                  iErrClr,
    output logic                  oOverflow,
    output logic                  oUnderflow,
`endif
    output logic [7:0]            oRdData,
    output logic                  oEmpty,
    output logic [DEPTH_LOG2:0]   oCount
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCnt  = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] AfullCnt = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);
    localparam logic [DEPTH_LOG2:0] CntOne   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  wr_acc, rd_acc;

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = iRdEn & ~empty_q;
        wr_acc = iWrEn & (~full_q | rd_acc);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        count_d   = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PtrOne;
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FullCnt);
        empty_d = (count_d == '0);
        afull_d = (count_d >= AfullCnt);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
        end
    end

    // Storage is deliberately left unreset; reset only discards it via the pointers.
    always_ff @(posedge iClk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= iWrData;
        end
    end

    assign oRdData     = rd_data_q;
    assign oFull       = full_q;
    assign oEmpty      = empty_q;
    assign oAlmostFull = afull_q;
    assign oCount      = count_q;

`ifdef FTDI_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Clear takes priority over a same-cycle set.
    always_comb begin
        overflow_d  = overflow_q | (iWrEn & ~wr_acc);
        underflow_d = underflow_q | (iRdEn & ~rd_acc);
        if (iErrClr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign oOverflow  = overflow_q;
    assign oUnderflow = underflow_q;
`endif

endmodule
